// File: rtl/conv2_pkg.sv
// conv2_pkg: shared state encoding and width constants for the layer-2 datapath
package conv2_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, BIAS, OUT} state_t;
  localparam int PSUM_WIDTH = 30;
  localparam int ACC_WIDTH = 35;
  localparam int OUT_WIDTH = 15;
  localparam int OUT_MAX = (1 << (OUT_WIDTH - 1)) - 1;
endpackage

// File: rtl/conv2_requant.sv
// conv2_requant: ReLU, round-half-up, arithmetic right shift and saturation of a signed sum
module conv2_requant
  import conv2_pkg::*;
#(
  parameter int SUM_WIDTH = ACC_WIDTH,
  parameter int SHIFT = 8,
  parameter int Q_WIDTH = OUT_WIDTH
) (
  input  logic [SUM_WIDTH-1:0] sum,
  output logic [Q_WIDTH-1:0]   q
);
  localparam int W = SUM_WIDTH + 1;
  localparam logic [W-1:0] MAX = W'((1 << (Q_WIDTH - 1)) - 1);
  logic [W-1:0] rnd;
  // one guard bit keeps the rounding add from wrapping on the largest positive sums
  assign rnd = ({1'b0, sum} + W'(1 << (SHIFT - 1))) >> SHIFT;
  assign q = sum[SUM_WIDTH-1] ? '0 : (rnd > MAX) ? MAX[Q_WIDTH-1:0] : rnd[Q_WIDTH-1:0];
endmodule

// File: rtl/conv2_channel_accum.sv
// conv2_channel_accum: sums per-channel partial sums, adds bias and requantises to a ready/valid word
module conv2_channel_accum
  import conv2_pkg::*;
#(
  parameter int PSUM_W = PSUM_WIDTH,
  parameter int ACC_W = ACC_WIDTH,
  parameter int BIAS_WIDTH = 8,
  parameter int BIAS_SHIFT = 4,
  parameter int OUT_SHIFT = 8,
  parameter int OUT_W = OUT_WIDTH,
  parameter int MAX_CH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4:0]            ch_num,
  input  logic [BIAS_WIDTH-1:0] bias,
  input  logic [PSUM_W-1:0]     psum_in,
  input  logic                  psum_valid,
  output logic [OUT_W-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  err
);
  state_t state;
  logic [ACC_W-1:0] acc, psum_ext, bias_ext, sum_b;
  logic [4:0] ch_cnt, ch_tgt, tgt;
  logic [BIAS_WIDTH-1:0] bias_r;
  logic [OUT_W-1:0] q;
  assign tgt = (ch_num == 5'd0) ? 5'd1 : (ch_num > 5'(MAX_CH)) ? 5'(MAX_CH) : ch_num;
  assign psum_ext = {{(ACC_W-PSUM_W){psum_in[PSUM_W-1]}}, psum_in};
  assign bias_ext = {{(ACC_W-BIAS_WIDTH-BIAS_SHIFT){bias_r[BIAS_WIDTH-1]}}, bias_r, {BIAS_SHIFT{1'b0}}};
  assign sum_b = acc + bias_ext;
  assign busy = state != IDLE;
  conv2_requant #(.SUM_WIDTH(ACC_W), .SHIFT(OUT_SHIFT), .Q_WIDTH(OUT_W)) u_requant (
    .sum(sum_b),
    .q(q)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      ch_cnt <= '0;
      ch_tgt <= '0;
      bias_r <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      err <= err | (psum_valid && state != ACCUM);
      case (state)
        IDLE: if (start) begin
          state <= ACCUM;
          ch_tgt <= tgt;
          bias_r <= bias;
          acc <= '0;
          ch_cnt <= '0;
          err <= psum_valid;
        end
        ACCUM: if (psum_valid) begin
          acc <= acc + psum_ext;
          ch_cnt <= ch_cnt + 5'd1;
          if (ch_cnt == ch_tgt - 5'd1) state <= BIAS;
        end
        BIAS: begin
          acc <= sum_b;
          out_data <= q;
          out_valid <= 1'b1;
          state <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_conv2_channel_accum.sv
// tb_conv2_channel_accum: directed vectors with hand-computed results for the channel accumulator
module tb_conv2_channel_accum;
  logic clk = 0, rst_n = 0, start = 0, psum_valid = 0, out_ready = 1;
  logic [4:0] ch_num = 0;
  logic [7:0] bias = 0;
  logic [29:0] psum_in = 0;
  logic [14:0] out_data;
  logic out_valid, busy, err;
  int checks = 0, failures = 0;
  logic [29:0] ps[$];
  always #5 clk = ~clk;
  conv2_channel_accum dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ch_num(ch_num), .bias(bias),
    .psum_in(psum_in), .psum_valid(psum_valid), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .err(err)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic pixel(input string tag, input int ch, input int b, input int exp, input bit sv);
    @(negedge clk);
    start = 1; ch_num = 5'(ch); bias = 8'(b); psum_valid = sv; psum_in = 30'd1000;
    @(negedge clk);
    start = 0; psum_valid = 0;
    check({tag, "_busy"}, busy, 1);
    while (ps.size() > 0) begin
      psum_valid = 1; psum_in = ps.pop_front();
      @(negedge clk);
    end
    psum_valid = 0;
    check({tag, "_bias_nv"}, out_valid, 0);
    check({tag, "_bias_busy"}, busy, 1);
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"}, out_data, exp);
  endtask
  task automatic xfer(input string tag);
    out_ready = 1;
    @(negedge clk);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_vdrop"}, out_valid, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_data", out_data, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    rst_n = 1;
    @(negedge clk); psum_valid = 1;
    @(negedge clk); psum_valid = 0;
    check("idle_psum_err", err, 1);
    ps = '{30'd256, 30'd512, 30'd768};
    pixel("p3", 3, 0, 6, 0);
    check("start_clears_err", err, 0);
    xfer("p3");
    ps = '{30'd100, -30'sd200};
    pixel("neg", 2, -1, 0, 0);
    xfer("neg");
    ps = '{30'd384};
    pixel("half", 1, 0, 2, 0);
    xfer("half");
    ps = '{30'h1FFF_FFFF};
    pixel("sat", 1, 0, 16383, 0);
    xfer("sat");
    ps = '{30'd1000};
    pixel("ch0", 0, 0, 4, 0);
    xfer("ch0");
    for (int i = 0; i < 16; i++) ps.push_back(30'd256);
    pixel("ch20", 20, 0, 16, 0);
    xfer("ch20");
    ps = '{30'd0};
    pixel("bias127", 1, 127, 8, 0);
    xfer("bias127");
    ps = '{30'd256};
    pixel("start_psum", 1, 0, 1, 1);
    check("start_psum_err", err, 1);
    xfer("start_psum");
    out_ready = 0;
    ps = '{30'd2560};
    pixel("bp", 1, 0, 10, 0);
    for (int i = 0; i < 5; i++) begin
      psum_valid = (i == 2);
      @(negedge clk);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_data", out_data, 10);
    end
    psum_valid = 0;
    check("bp_out_err", err, 1);
    xfer("bp");
    check("bp_data_kept", out_data, 10);
    @(negedge clk);
    start = 1; ch_num = 5'd4; bias = 8'd5;
    @(negedge clk);
    start = 0;
    repeat (2) begin
      psum_valid = 1; psum_in = 30'd5000;
      @(negedge clk);
    end
    psum_valid = 0; rst_n = 0;
    #1;
    check("mid_rst_data", out_data, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", err, 0);
    @(negedge clk); rst_n = 1;
    ps = '{30'd300, 30'd300, 30'd300, 30'd300};
    pixel("post_rst", 4, 0, 5, 0);
    xfer("post_rst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
